// File: rtl/add8_reg_pkg.sv
// Shared constants for the registered adder slice.
package add8_reg_pkg;
  localparam int unsigned ADD_W = 8;
endpackage

// File: rtl/add8_reg_full_adder_cell.sv
// Single-bit full adder; rippled by add8_reg to form the carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/add8_reg.sv
// Registered ripple-carry adder with carry-in; sum, carry, signed overflow and
// zero flags are captured one cycle after in_valid and qualified by out_valid.
module add8_reg
  import add8_reg_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             overflow_c;
  logic             zero_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Overflow: like-signed operands producing a result of the other sign.
  always_comb begin
    overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
    zero_c     = (sum_c == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_c;
        cout     <= carry[WIDTH];
        overflow <= overflow_c;
        zero     <= zero_c;
      end
    end
  end
endmodule

// File: tb/tb_add8_reg.sv
// Directed self-checking bench for add8_reg with hand-computed expectations.
module tb_add8_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  add8_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic co,
                            input logic ov, input logic z, input logic v);
    chk({tag, ".sum"}, sum, s);
    chk({tag, ".cout"}, {7'd0, cout}, {7'd0, co});
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, ov});
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, z});
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [7:0] ai,
                      input logic [7:0] bi, input logic ci);
    rst = r; in_valid = v; a = ai; b = bi; cin = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(1, 0, 8'h00, 8'h00, 0);
    step(1, 0, 8'h00, 8'h00, 0);
    expect_out("reset", 8'h00, 0, 0, 0, 0);

    step(0, 1, 8'h01, 8'h00, 1); expect_out("01+00+1", 8'h02, 0, 0, 0, 1);
    step(0, 1, 8'hFF, 8'hFF, 1); expect_out("FF+FF+1", 8'hFF, 1, 0, 0, 1);
    step(0, 1, 8'h70, 8'h7F, 1); expect_out("70+7F+1", 8'hF0, 0, 1, 0, 1);
    step(0, 1, 8'h55, 8'hAA, 0); expect_out("55+AA+0", 8'hFF, 0, 0, 0, 1);
    step(0, 1, 8'h55, 8'hAA, 1); expect_out("55+AA+1", 8'h00, 1, 0, 1, 1);
    step(0, 1, 8'h80, 8'h80, 0); expect_out("80+80+0", 8'h00, 1, 1, 1, 1);

    // Carry-chain sweep: FF + b + 1 wraps to b with carry out.
    step(0, 1, 8'hFF, 8'h00, 1); expect_out("sweep00", 8'h00, 1, 0, 1, 1);
    step(0, 1, 8'hFF, 8'h01, 1); expect_out("sweep01", 8'h01, 1, 0, 0, 1);
    step(0, 1, 8'hFF, 8'h0F, 1); expect_out("sweep0F", 8'h0F, 1, 0, 0, 1);
    step(0, 1, 8'hFF, 8'h1F, 1); expect_out("sweep1F", 8'h1F, 1, 0, 0, 1);
    step(0, 1, 8'hFF, 8'h5F, 1); expect_out("sweep5F", 8'h5F, 1, 0, 0, 1);

    step(0, 1, 8'h12, 8'h34, 0); expect_out("b2b0", 8'h46, 0, 0, 0, 1);
    step(0, 1, 8'h7F, 8'h01, 0); expect_out("b2b1", 8'h80, 0, 1, 0, 1);
    step(0, 1, 8'hC0, 8'h50, 0); expect_out("b2b2", 8'h10, 1, 0, 0, 1);

    // Idle cycles: flags and sum hold, only out_valid drops.
    step(0, 0, 8'h01, 8'h01, 0); expect_out("hold0", 8'h10, 1, 0, 0, 0);
    step(0, 0, 8'hFF, 8'hFF, 1); expect_out("hold1", 8'h10, 1, 0, 0, 0);

    step(0, 1, 8'h7F, 8'h00, 1); expect_out("pre_rst", 8'h80, 0, 1, 0, 1);
    step(1, 1, 8'h0F, 8'h04, 1); expect_out("rst_drop", 8'h00, 0, 0, 0, 0);
    step(0, 0, 8'h0F, 8'h04, 1); expect_out("rst_after", 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'h03, 8'h04, 0); expect_out("first_op", 8'h07, 0, 0, 0, 1);
    step(0, 0, 8'h00, 8'h00, 0); expect_out("tail", 8'h07, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
